// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - WS2812B frame scheduler: pixel buffer, pixel streaming, latch interval
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   wr_en/addr/grb     host pixel write; dropped with wr_err pulse while busy
//   start              single-cycle frame request; a request while busy is held as pending
//   busy, frame_done   frame in progress / end-of-latch pulse
//   pix_valid/grb      pixel offered to the encoder, pix_ready accepts it
//   enc_idle           encoder has fully finished its last bit
//   latch_active       line held low for the reset/latch interval
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int RESET_CYCLES = 1400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_grb,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              wr_err,
  output logic              pix_valid,
  output logic [23:0]       pix_grb,
  input  logic              pix_ready,
  input  logic              enc_idle,
  output logic              latch_active
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_OFFER, S_DRAIN, S_LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       pbuf_q [NUM_LEDS];
  logic [23:0]       pbuf_d [NUM_LEDS];
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [23:0]       pix_grb_q, pix_grb_d;
  logic              frame_done_q, frame_done_d;
  logic              wr_err_q, wr_err_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start || pending_q) state_d = S_FETCH;
      S_FETCH: state_d = S_OFFER;
      S_OFFER: if (pix_ready) state_d = (idx_q == LAST_IDX) ? S_DRAIN : S_FETCH;
      S_DRAIN: if (enc_idle) state_d = S_LATCH;
      S_LATCH: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy         = (state_q != S_IDLE);
    pix_valid    = (state_q == S_OFFER);
    latch_active = (state_q == S_LATCH);
  end

  // Datapath next values
  always_comb begin
    pbuf_d = pbuf_q;
    // Address decode by comparison so out-of-range addresses match no entry.
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (wr_en && !busy && (wr_addr == ADDR_W'(i))) pbuf_d[i] = wr_grb;
    end
    wr_err_d = wr_en && busy;

    // One pending slot: any start seen while busy is folded into it; IDLE
    // always consumes it because leaving IDLE is the launch.
    pending_d = pending_q;
    if (state_q == S_IDLE) pending_d = 1'b0;
    else if (start)        pending_d = 1'b1;

    idx_d = idx_q;
    if (state_q == S_IDLE) idx_d = '0;
    else if (state_q == S_OFFER && pix_ready && idx_q != LAST_IDX) idx_d = idx_q + ADDR_W'(1);

    pix_grb_d = pix_grb_q;
    if (state_q == S_FETCH) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (idx_q == ADDR_W'(i)) pix_grb_d = pbuf_q[i];
      end
    end

    cnt_d = cnt_q;
    if (state_q == S_DRAIN && enc_idle)        cnt_d = CNT_START;
    else if (state_q == S_LATCH && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);

    frame_done_d = (state_q == S_LATCH) && (cnt_q == '0);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) pbuf_q[i] <= 24'h0;
      idx_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      pix_grb_q    <= 24'h0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      pbuf_q       <= pbuf_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      pix_grb_q    <= pix_grb_d;
      frame_done_q <= frame_done_d;
      wr_err_q     <= wr_err_d;
    end
  end

  assign pix_grb    = pix_grb_q;
  assign frame_done = frame_done_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - self-checking bench for ws2812_frame_ctrl
module tb_ws2812_frame_ctrl;
  localparam int N  = 8;
  localparam int AW = 4;
  localparam int RC = 1400;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, start, pix_ready, enc_idle;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_grb;
  logic          busy, frame_done, wr_err, pix_valid, latch_active;
  logic [23:0]   pix_grb;

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(.NUM_LEDS(N), .ADDR_W(AW), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_grb(wr_grb),
    .start(start), .busy(busy), .frame_done(frame_done), .wr_err(wr_err),
    .pix_valid(pix_valid), .pix_grb(pix_grb), .pix_ready(pix_ready),
    .enc_idle(enc_idle), .latch_active(latch_active)
  );

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mdl_buf [N];
  int xfer_total = 0, done_total = 0, err_total = 0, latch_cnt = 0;
  int cyc = 0, last_xfer = 0;
  bit have_last = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    logic          exp_err;
  } wvec_t;
  wvec_t wtab [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back(mdl_buf[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_total < target; i++) tick();
    check("frame_done count", done_total, target);
  endtask

  task automatic wait_xfer(input int target);
    for (int i = 0; i < 500 && xfer_total < target; i++) tick();
    check("transfer count", xfer_total, target);
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        latch_cnt  = 0;
        have_last  = 0;
        prev_valid = 1'b0;
      end else begin
        if (pix_valid && !prev_valid && have_last) check("pixel gap", cyc - last_xfer, 2);
        if (pix_valid && pix_ready) begin
          xfer_total++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected pixel: got 0x%06h, required none", pix_grb);
          end else begin
            e = exp_q.pop_front();
            check("pixel data", pix_grb, e);
          end
          last_xfer = cyc;
          have_last = 1;
        end
        if (latch_active) latch_cnt++;
        if (wr_err) err_total++;
        if (frame_done) begin
          done_total++;
          check("latch length", latch_cnt, RC);
          check("busy at frame_done", busy, 0);
          latch_cnt = 0;
          have_last = 0;
        end
        prev_valid = pix_valid;
      end
    end
  end

  initial begin
    int d0, x0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_grb = '0;
    start = 1'b0; pix_ready = 1'b1; enc_idle = 1'b1;
    for (int i = 0; i < N; i++) mdl_buf[i] = 24'h0;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    check("reset wr_err", wr_err, 0);
    check("reset pix_valid", pix_valid, 0);
    check("reset pix_grb", pix_grb, 0);
    check("reset latch_active", latch_active, 0);
    rst_n = 1'b1;
    tick();

    // Idle writes, including two out-of-range addresses that must be ignored.
    for (int i = 0; i < N; i++) wtab[i] = '{AW'(i), 24'(i + 1), 1'b0};
    wtab[8] = '{AW'(9), 24'hFFFFFF, 1'b0};
    wtab[9] = '{AW'(15), 24'hABCDEF, 1'b0};
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = wtab[i].addr; wr_grb = wtab[i].data;
      tick();
      wr_en = 1'b0;
      check("wr_err idle write", wr_err, wtab[i].exp_err);
      if (wtab[i].addr < N) mdl_buf[wtab[i].addr] = wtab[i].data;
    end

    // Basic frame with latency checks.
    d0 = done_total;
    push_frame();
    pulse_start();
    check("busy after start", busy, 1);
    check("pix_valid in fetch", pix_valid, 0);
    tick();
    check("pix_valid after edge1", pix_valid, 1);
    check("first pixel", pix_grb, 24'h000001);
    wait_done(d0 + 1);
    check("queue empty frame1", exp_q.size(), 0);

    // Encoder stall on pixel index 3.
    d0 = done_total;
    x0 = xfer_total;
    push_frame();
    pulse_start();
    wait_xfer(x0 + 3);
    pix_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall pix_valid", pix_valid, 1);
      check("stall pix_grb", pix_grb, 24'h000004);
      tick();
    end
    pix_ready = 1'b1;
    wait_done(d0 + 1);
    check("queue empty stall", exp_q.size(), 0);

    // Write while busy is dropped.
    d0 = done_total;
    push_frame();
    pulse_start();
    tick();
    wr_en = 1'b1; wr_addr = AW'(2); wr_grb = 24'hFFFFFF;
    tick();
    wr_en = 1'b0;
    check("wr_err on busy write", wr_err, 1);
    tick();
    check("wr_err single pulse", wr_err, 0);
    wait_done(d0 + 1);
    check("queue empty busy write", exp_q.size(), 0);

    // Two starts during latch give exactly one extra frame.
    d0 = done_total;
    push_frame();
    pulse_start();
    for (int i = 0; i < 200 && !latch_active; i++) tick();
    check("reached latch", latch_active, 1);
    repeat (5) tick();
    pulse_start();
    repeat (3) tick();
    pulse_start();
    push_frame();
    for (int i = 0; i < 2000 && !frame_done; i++) tick();
    check("first frame_done", frame_done, 1);
    check("busy low at done", busy, 0);
    tick();
    check("pending relaunch busy", busy, 1);
    check("frame_done one cycle", frame_done, 0);
    wait_done(d0 + 2);
    repeat (20) tick();
    check("no third frame", busy, 0);
    check("done count pending", done_total, d0 + 2);
    check("queue empty pending", exp_q.size(), 0);

    // Reset during OFFER of pixel index 5.
    x0 = xfer_total;
    push_frame();
    pulse_start();
    wait_xfer(x0 + 5);
    tick();
    check("offer pixel 5", pix_valid, 1);
    d0 = done_total;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort pix_valid", pix_valid, 0);
    check("abort pix_grb", pix_grb, 0);
    check("abort latch_active", latch_active, 0);
    check("abort frame_done", frame_done, 0);
    check("abort wr_err", wr_err, 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) mdl_buf[i] = 24'h0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("no done on abort", done_total, d0);
    d0 = done_total;
    push_frame();
    pulse_start();
    wait_done(d0 + 1);
    check("queue empty after reset", exp_q.size(), 0);

    // enc_idle held low after the last transfer.
    enc_idle = 1'b0;
    d0 = done_total;
    x0 = xfer_total;
    push_frame();
    pulse_start();
    wait_xfer(x0 + 8);
    repeat (50) tick();
    check("latch held off", latch_active, 0);
    check("latch cycles before idle", latch_cnt, 0);
    check("still busy in drain", busy, 1);
    enc_idle = 1'b1;
    wait_done(d0 + 1);
    check("queue empty drain", exp_q.size(), 0);

    check("wr_err pulse total", err_total, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
Frame scheduler for a WS2812B LED chain. It holds an NUM_LEDS-entry GRB pixel buffer that the host writes. On a start request it streams the pixels in order, over a valid/ready handshake, to the single-pixel bit encoder that drives the data line. After the last pixel has been shifted out, it enforces the latch/reset low interval. It sits between host/pattern logic and the per-pixel encoder, and is the only master of the encoder.

Parameters:
NUM_LEDS, 8, number of pixels in the chain; must be ≥1.
ADDR_W, 3, pixel index width; must satisfy 2^ADDR_W ≥ NUM_LEDS.
RESET_CYCLES, 1400, number of clk cycles the line is held low after a frame (280 us at 5 MHz).

Ports:
clk  in  1  system clock, 5 MHz nominal (one cycle = 0.2 us).
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  pixel buffer write strobe.
wr_addr  in  ADDR_W  pixel index to write; writes with wr_addr ≥ NUM_LEDS are ignored.
wr_grb  in  24  pixel colour as {g,r,b}, MSB first on the wire.
start  in  1  single-cycle frame request.
busy  out  1  high from the cycle after an accepted start until frame_done.
frame_done  out  1  one-cycle pulse at the end of the latch interval.
wr_err  out  1  one-cycle pulse when a write is dropped because busy=1.
pix_valid  out  1  pix_grb is valid for the encoder.
pix_grb  out  24  pixel offered to the encoder.
pix_ready  in  1  encoder can accept a pixel.
enc_idle  in  1  encoder has finished the last bit, including its low phase.
latch_active  out  1  high during the reset/latch low interval.

Behaviour:
- Async reset clears the following: state=IDLE, busy=0, frame_done=0, wr_err=0, pix_valid=0, pix_grb=0, latch_active=0, pixel index=0, latch counter=0, pending=0, and all buffer entries=24'h0. Assertion mid-frame aborts the frame immediately; no frame_done is produced.
- Buffer: flop array. Writes take effect when wr_en=1 and busy=0. When wr_en=1 and busy=1, the write is dropped and wr_err pulses on the next cycle.
- Same-cycle wr_en and start in IDLE: the write commits first, and the frame transmits the new value.
- States:
  - IDLE: on start, or on pending=1, go to FETCH with idx=0 and clear pending.
  - FETCH: register buf[idx] into pix_grb, then go to OFFER.
  - OFFER: pix_valid=1, and pix_grb is held stable. A transfer occurs on the posedge where pix_valid&pix_ready=1.
    - After a transfer with idx<NUM_LEDS-1: idx+1, go to FETCH.
    - After a transfer with idx=NUM_LEDS-1: go to DRAIN.
    - pix_valid drops in the cycle after a transfer.
  - DRAIN: wait for enc_idle=1, then go to LATCH with the counter loaded to RESET_CYCLES-1.
  - LATCH: latch_active=1 and the counter decrements each cycle. At 0, go to IDLE and pulse frame_done.
- Latency:
  - start sampled at edge 0: busy=1 and state FETCH after edge 0; pix_valid=1 after edge 1.
  - Inter-pixel gap with pix_ready tied high: 2 cycles from transfer to next pix_valid. This is well below the WS2812B reset threshold.
- latch_active is high for exactly RESET_CYCLES cycles. frame_done and busy=0 occur in the same cycle as the IDLE entry.
- start while busy=1 sets pending (depth 1; extra starts are absorbed). A pending start launches a new frame one cycle after IDLE entry, so busy is low for exactly 1 cycle.
- pix_ready is ignored outside OFFER. enc_idle is ignored outside DRAIN.
- idx never exceeds NUM_LEDS-1 (no wrap).

Test Plan:
- Reset, write buf[0..7]=24'h000001..24'h000008, start, pix_ready=1, enc_idle=1 → 8 transfers in order 000001..000008, each pix_valid 2 cycles apart; latch_active high for 1400 cycles; then frame_done single pulse and busy=0.
- pix_ready held low for 10 cycles during pixel 3 → pix_valid stays high and pix_grb stays constant at 24'h000004 throughout; pixel 4 is offered only after the transfer.
- During busy, write wr_addr=2 with 24'hFFFFFF → wr_err pulses; a following frame still sends 24'h000003 at index 2. Also: wr_addr=9 while idle → no entry changes.
- start pulsed twice during LATCH → busy drops for exactly 1 cycle after frame_done, then exactly one second frame runs.
- rst_n asserted low during OFFER of pixel 5 → all outputs 0 immediately, no frame_done; after release, buffer reads 0 and a new start sends 8× 24'h000000.
- enc_idle held low for 50 cycles after the last transfer → latch_active does not rise until enc_idle=1, then holds high for exactly 1400 cycles.
